// File: rtl/serial_demux.sv
// Serial-to-parallel receiver: frames LSB-first bits behind a start marker and
// steers each completed word to one of NCH channels via one-hot valid/ready.
module serial_demux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    localparam int SELW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_valid,
    input  logic             start,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] q,
    output logic [NCH-1:0]   q_valid,
    input  logic [NCH-1:0]   q_ready,
    output logic             busy,
    output logic             ovf,
    output logic             frame_err,
    input  logic             err_clr
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  shreg;
    logic [CW-1:0]     cnt;
    logic [SELW-1:0]   sel_lat;

    logic              start_bit;
    logic              data_bit;
    logic              last_bit;
    logic              xfer;
    logic              hold_free;
    logic              sel_ok;
    logic              load;
    logic [NCH-1:0]    onehot;
    logic [WIDTH-1:0]  word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        start_bit = d_valid && start;
        data_bit  = d_valid && !start && (state == SHIFT);
        last_bit  = data_bit && (cnt == CW'(WIDTH - 1));
        xfer      = |(q_valid & q_ready);
        hold_free = (q_valid == '0) || xfer;
        word      = shreg;
        word[WIDTH-1] = d;

        // Decoding through a loop doubles as the range check for sel_lat.
        onehot = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_lat == SELW'(k)) onehot[k] = 1'b1;
        end
        sel_ok = |onehot;
        load   = last_bit && sel_ok && hold_free;

        case (state)
            IDLE:    if (start_bit) state_nx = SHIFT;
            SHIFT:   if (last_bit)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    // A start always begins a fresh frame, even when it aborts one in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
            sel_lat <= '0;
        end else if (start_bit) begin
            shreg[0] <= d;
            cnt      <= CW'(1);
            sel_lat  <= sel;
        end else if (data_bit) begin
            shreg[cnt] <= d;
            cnt        <= last_bit ? '0 : cnt + CW'(1);
        end
    end

    // Loading takes precedence over clearing so back-to-back words see no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= '0;
        end else if (load) begin
            q       <= word;
            q_valid <= onehot;
        end else if (xfer) begin
            q_valid <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (last_bit && sel_ok && !hold_free) ovf <= 1'b1;
            else if (err_clr)                     ovf <= 1'b0;
            if ((start_bit && state == SHIFT) || (last_bit && !sel_ok)) frame_err <= 1'b1;
            else if (err_clr)                                           frame_err <= 1'b0;
        end
    end

endmodule
